// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch prediction unit.
// Holds the default parameter values, the 2-bit direction counter encoding
// and the saturating counter step used by the pattern history table.
// The BTB entry (valid, tag, target) is declared as a packed struct inside
// branch_predict_unit, because its field widths follow the module parameters.
package branch_predict_unit_pkg;

    localparam int PC_W_DEF      = 5;
    localparam int GHR_W_DEF     = 4;
    localparam int BTB_IDX_W_DEF = 3;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int CNT_W_DEF     = 16;

    // Direction counter encoding: strongly/weakly not-taken, weakly/strongly taken.
    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_return_addr_stack.sv
// Circular return-address stack.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push_i          push push_addr_i (call fetched)
//   pop_i           pop request (return fetched); ignored when empty
//   flush_i         empty the stack; wins over push/pop
//   push_addr_i     return address to push
//   top_o           most recently pushed live entry
//   valid_o         stack holds at least one entry
// Overflow silently overwrites the oldest entry; count saturates at depth.
module return_addr_stack
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] push_addr_i,
    output logic [PC_W-1:0] top_o,
    output logic            valid_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  stack_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, top_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;

    // Pointer addresses the next free slot; the top lives one below it (mod depth).
    assign top_ptr = ptr_q - PTR_W'(1);
    assign top_o   = stack_q[top_ptr];
    assign valid_o = (cnt_q != '0);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i && valid_o) begin
            // Call and return together: replace the top in place.
            wr_en  = 1'b1;
            wr_ptr = top_ptr;
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && valid_o) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            stack_q[wr_ptr] <= push_addr_i;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Gshare direction predictor + tagged direct-mapped BTB + return-address stack.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   fetch_pc/is_ret/is_call      fetch-stage lookup request
//   pred_taken/target/hit/idx    combinational prediction (idx travels down the pipe)
//   upd_valid/pc/idx/taken/target  conditional-branch resolution from execute
//   upd_mispredict               any redirect issued; bumps mispredict_count
//   ras_flush                    empty the return stack
//   mispredict_count             saturating mispredict counter
// Lookups see state before the same-cycle update (no bypass).
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int GHR_W     = GHR_W_DEF,
    parameter int BTB_IDX_W = BTB_IDX_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  fetch_pc,
    input  logic             fetch_is_ret,
    input  logic             fetch_is_call,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    output logic             pred_hit,
    output logic [GHR_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [GHR_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_mispredict,
    input  logic             ras_flush,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int PHT_N = 2 ** GHR_W;
    localparam int BTB_N = 2 ** BTB_IDX_W;
    localparam int TAG_W = PC_W - BTB_IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
    } btb_entry_t;

    logic [1:0]       pht_q [PHT_N];
    logic [1:0]       pht_d [PHT_N];
    btb_entry_t       btb_q [BTB_N];
    btb_entry_t       btb_d [BTB_N];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    btb_entry_t       btb_rd;
    logic [PC_W-1:0]  pc_plus1;
    logic [PC_W-1:0]  ras_top;
    logic             ras_valid;

    return_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fetch_is_call),
        .pop_i       (fetch_is_ret),
        .flush_i     (ras_flush),
        .push_addr_i (pc_plus1),
        .top_o       (ras_top),
        .valid_o     (ras_valid)
    );

    // Lookup
    assign pc_plus1 = fetch_pc + PC_W'(1);
    assign pred_idx = fetch_pc[GHR_W-1:0] ^ ghr_q;
    assign btb_rd   = btb_q[fetch_pc[BTB_IDX_W-1:0]];
    assign pred_hit = btb_rd.valid && (btb_rd.tag == fetch_pc[PC_W-1:BTB_IDX_W]);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus1;
        if (fetch_is_ret && ras_valid) begin
            pred_taken  = 1'b1;
            pred_target = ras_top;
        end else if (pred_hit && pht_q[pred_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = btb_rd.target;
        end
    end

    // Update
    always_comb begin
        pht_d = pht_q;
        btb_d = btb_q;
        ghr_d = ghr_q;
        if (upd_valid) begin
            pht_d[upd_idx] = ctr_next(pht_q[upd_idx], upd_taken);
            ghr_d          = (ghr_q << 1) | GHR_W'(upd_taken);
            if (upd_taken) begin
                btb_d[upd_pc[BTB_IDX_W-1:0]] = '{valid:  1'b1,
                                                 tag:    upd_pc[PC_W-1:BTB_IDX_W],
                                                 target: upd_target};
            end
        end
    end

    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (upd_mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_WNT;
            for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
            ghr_q     <= '0;
            mis_cnt_q <= '0;
        end else begin
            pht_q     <= pht_d;
            btb_q     <= btb_d;
            ghr_q     <= ghr_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    localparam int PC_W = 5, GHR_W = 4, BTB_IDX_W = 3, RAS_DEPTH = 4, CNT_W = 16;
    localparam int PC_N = 32, PHT_N = 16, BTB_N = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [PC_W-1:0]  fetch_pc;
    logic             fetch_is_ret, fetch_is_call;
    logic             pred_taken, pred_hit;
    logic [PC_W-1:0]  pred_target;
    logic [GHR_W-1:0] pred_idx;
    logic             upd_valid, upd_taken, upd_mispredict, ras_flush;
    logic [PC_W-1:0]  upd_pc, upd_target;
    logic [GHR_W-1:0] upd_idx;
    logic [CNT_W-1:0] mispredict_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_pht [PHT_N];
    int m_bv  [BTB_N];
    int m_bpc [BTB_N];
    int m_btg [BTB_N];
    int m_ghr;
    int m_cnt;
    int ras_q [$];

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_pc         (fetch_pc),
        .fetch_is_ret     (fetch_is_ret),
        .fetch_is_call    (fetch_is_call),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_hit         (pred_hit),
        .pred_idx         (pred_idx),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_idx          (upd_idx),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .ras_flush        (ras_flush),
        .mispredict_count (mispredict_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
        for (int i = 0; i < BTB_N; i++) begin
            m_bv[i] = 0; m_bpc[i] = 0; m_btg[i] = 0;
        end
        m_ghr = 0;
        m_cnt = 0;
        ras_q.delete();
    endtask

    function automatic int m_idx(input int pc);
        return (pc ^ m_ghr) % PHT_N;
    endfunction

    task automatic check_outputs();
        int pc, idx, hit, tk, tg;
        pc  = int'(fetch_pc);
        idx = m_idx(pc);
        hit = (m_bv[pc % BTB_N] != 0 && m_bpc[pc % BTB_N] == pc) ? 1 : 0;
        tk  = 0;
        tg  = (pc + 1) % PC_N;
        if (fetch_is_ret && ras_q.size() > 0) begin
            tk = 1; tg = ras_q[ras_q.size()-1];
        end else if (hit != 0 && m_pht[idx] >= 2) begin
            tk = 1; tg = m_btg[pc % BTB_N];
        end
        chk("pred_idx", 32'(pred_idx), 32'(idx));
        chk("pred_hit", 32'(pred_hit), 32'(hit));
        chk("pred_taken", 32'(pred_taken), 32'(tk));
        chk("pred_target", 32'(pred_target), 32'(tg));
        chk("mispredict_count", 32'(mispredict_count), 32'(m_cnt));
    endtask

    task automatic model_update();
        int pc;
        pc = int'(fetch_pc);
        if (reset) begin
            model_reset();
            return;
        end
        if (upd_valid) begin
            if (upd_taken) begin
                if (m_pht[upd_idx] < 3) m_pht[upd_idx]++;
                m_bv[int'(upd_pc) % BTB_N]  = 1;
                m_bpc[int'(upd_pc) % BTB_N] = int'(upd_pc);
                m_btg[int'(upd_pc) % BTB_N] = int'(upd_target);
            end else if (m_pht[upd_idx] > 0) begin
                m_pht[upd_idx]--;
            end
            m_ghr = ((m_ghr << 1) | int'(upd_taken)) % PHT_N;
        end
        if (upd_mispredict && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (ras_flush) begin
            ras_q.delete();
        end else if (fetch_is_call && fetch_is_ret && ras_q.size() > 0) begin
            ras_q[ras_q.size()-1] = (pc + 1) % PC_N;
        end else if (fetch_is_call) begin
            ras_q.push_back((pc + 1) % PC_N);
            if (ras_q.size() > RAS_DEPTH) ras_q.delete(0);
        end else if (fetch_is_ret && ras_q.size() > 0) begin
            ras_q.delete(ras_q.size()-1);
        end
    endtask

    // Inputs are driven just after the falling edge; outputs checked 1ns later.
    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; fetch_pc = '0; fetch_is_ret = 0; fetch_is_call = 0;
        upd_valid = 0; upd_pc = '0; upd_idx = '0; upd_taken = 0; upd_target = '0;
        upd_mispredict = 0; ras_flush = 0;
    endtask

    task automatic branch_upd(input int pc, input int idx, input int taken, input int tgt);
        upd_valid = 1; upd_pc = PC_W'(pc); upd_idx = GHR_W'(idx);
        upd_taken = taken[0]; upd_target = PC_W'(tgt);
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 0;

        // Reset state
        #1;
        chk("rst_taken", 32'(pred_taken), 0);
        chk("rst_target", 32'(pred_target), 1);
        chk("rst_hit", 32'(pred_hit), 0);
        chk("rst_idx", 32'(pred_idx), 0);
        chk("rst_count", 32'(mispredict_count), 0);
        @(negedge clk);

        // Train PC 6 -> 20
        fetch_pc = 5'd6;
        branch_upd(6, m_idx(6), 1, 20);
        cyc();
        upd_valid = 0;
        #1;
        chk("train_idx", 32'(pred_idx), 7);
        chk("train_hit", 32'(pred_hit), 1);
        chk("train_weak", 32'(pred_taken), 0);
        cyc();
        for (int i = 0; i < 8; i++) begin
            branch_upd(6, m_idx(6), 1, 20);
            cyc();
        end
        upd_valid = 0;
        #1;
        chk("train_taken", 32'(pred_taken), 1);
        chk("train_target", 32'(pred_target), 20);
        cyc();

        // Alias: same BTB index, different tag
        fetch_pc = 5'd14;
        #1;
        chk("alias_hit", 32'(pred_hit), 0);
        chk("alias_target", 32'(pred_target), 15);
        cyc();

        // RAS overflow and drain
        for (int p = 1; p <= 5; p++) begin
            fetch_pc = PC_W'(p); fetch_is_call = 1;
            cyc();
        end
        fetch_is_call = 0;
        fetch_is_ret  = 1;
        fetch_pc      = 5'd16;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ras_pop", 32'(pred_target), 32'(6 - k));
            cyc();
        end
        #1;
        chk("ras_empty_taken", 32'(pred_taken), 0);
        chk("ras_empty_target", 32'(pred_target), 17);
        cyc();

        // Simultaneous call and return replaces the top
        fetch_is_ret = 0; fetch_is_call = 1; fetch_pc = 5'd3;
        cyc();
        fetch_is_ret = 1; fetch_pc = 5'd9;
        #1;
        chk("ras_both_pred", 32'(pred_target), 4);
        cyc();
        fetch_is_call = 0; fetch_pc = 5'd16;
        #1;
        chk("ras_both_top", 32'(pred_target), 10);
        cyc();
        #1;
        chk("ras_both_count", 32'(pred_taken), 0);
        cyc();

        // Flush beats a same-cycle push
        fetch_is_ret = 0; fetch_is_call = 1; fetch_pc = 5'd1;
        cyc();
        ras_flush = 1; fetch_pc = 5'd7;
        cyc();
        ras_flush = 0; fetch_is_call = 0; fetch_is_ret = 1; fetch_pc = 5'd16;
        #1;
        chk("ras_flush", 32'(pred_taken), 0);
        cyc();

        // Randomised traffic, including occasional mid-run reset
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 99) == 0);
            fetch_pc       = PC_W'($urandom_range(0, PC_N - 1));
            fetch_is_call  = ($urandom_range(0, 3) == 0);
            fetch_is_ret   = ($urandom_range(0, 3) == 0);
            ras_flush      = ($urandom_range(0, 19) == 0);
            upd_mispredict = ($urandom_range(0, 2) == 0);
            upd_valid      = $urandom_range(0, 1) != 0;
            upd_pc         = PC_W'($urandom_range(0, PC_N - 1));
            upd_idx        = GHR_W'($urandom_range(0, PHT_N - 1));
            upd_taken      = $urandom_range(0, 1) != 0;
            upd_target     = PC_W'($urandom_range(0, PC_N - 1));
            cyc();
        end

        // Mispredict counter saturation
        idle();
        reset = 1;
        cyc();
        reset = 0;
        upd_mispredict = 1;
        for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
            @(posedge clk);
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        @(negedge clk);
        #1;
        chk("cnt_saturated", 32'(mispredict_count), 32'(16'hFFFF));
        cyc();
        upd_mispredict = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised gshare direction predictor, tagged branch-target buffer and return-address stack for the 5-stage MIPS pipeline.
- Lookup is combinational in fetch. Resolution updates arrive from the execute stage.
- Generalises the fixed 4-bit GHR / 5-bit PC predictor to configurable widths and depths.
- Adds return prediction for jal/jr $31, plus a mispredict counter.

Parameters:
- PC_W, 5, instruction-address width (word-addressed PC).
- GHR_W, 4, global history length; the PHT has 2**GHR_W entries. Constraint: GHR_W <= PC_W.
- BTB_IDX_W, 3, BTB has 2**BTB_IDX_W direct-mapped entries. Tag width is PC_W-BTB_IDX_W; constraint: BTB_IDX_W < PC_W.
- RAS_DEPTH, 4, return-stack entries (power of two, >= 2).
- CNT_W, 16, mispredict-counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- fetch_pc  in  PC_W  PC being fetched
- fetch_is_ret  in  1  fetched instruction is jr $31
- fetch_is_call  in  1  fetched instruction is jal (push fetch_pc+1)
- pred_taken  out  1  predicted redirect
- pred_target  out  PC_W  predicted next PC
- pred_hit  out  1  BTB tag hit
- pred_idx  out  GHR_W  PHT index used; carried down the pipe to the update
- upd_valid  in  1  a conditional branch (beq/bne) resolved in E
- upd_pc  in  PC_W  PC of the resolved branch
- upd_idx  in  GHR_W  pred_idx captured at fetch
- upd_taken  in  1  actual outcome
- upd_target  in  PC_W  actual taken target
- upd_mispredict  in  1  redirect/flush issued (any control type)
- ras_flush  in  1  clear the RAS (pipeline flush after a mispredicted call/return)
- mispredict_count  out  CNT_W  saturating count of mispredicts

Behaviour:
- Reset values:
  - All PHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - GHR = 0.
  - RAS pointer = 0, RAS count = 0.
  - mispredict_count = 0.
- Combinational outputs after reset with fetch inputs at 0: pred_taken=0, pred_target=1, pred_hit=0, pred_idx=0.
- Lookup is combinational, zero latency:
  - pred_idx = fetch_pc[GHR_W-1:0] ^ GHR.
  - pred_hit = BTB[fetch_pc[BTB_IDX_W-1:0]].valid && tag match.
- Priority:
  1. fetch_is_ret with RAS non-empty: pred_taken=1, pred_target=RAS top.
  2. pred_hit && PHT[pred_idx][1]: pred_taken=1, pred_target=BTB target.
  3. Otherwise: pred_taken=0, pred_target=fetch_pc+1, wrapping mod 2**PC_W.
- fetch_is_ret with an empty RAS falls through to BTB/PHT.
- Update (registered; visible one cycle after the upd_valid edge):
  - PHT[upd_idx] is a 2-bit saturating counter: increments if taken (saturates at 3), decrements if not (saturates at 0).
  - GHR <= {GHR[GHR_W-2:0], upd_taken}. GHR is non-speculative, updated only on upd_valid.
  - If upd_taken: BTB entry at upd_pc index <= valid=1, tag, upd_target. A not-taken outcome leaves the BTB unchanged.
- Same-cycle lookup and update of the same PHT or BTB entry: the lookup returns the old value; there is no bypass.
- RAS, circular buffer:
  - Push writes fetch_pc+1 at the pointer, then increments the pointer. count = min(count+1, RAS_DEPTH).
  - Overflow overwrites the oldest entry silently.
  - Pop (fetch_is_ret with count>0) decrements the pointer and count.
  - Pop on empty has no effect.
  - Simultaneous push and pop: overwrite the top entry in place; pointer and count unchanged.
- ras_flush: count <= 0 and pointer <= 0 next cycle. It has priority over push/pop in the same cycle.
- mispredict_count increments on upd_mispredict and saturates at all-ones.
- reset has priority over every update. Reset asserted mid-operation discards all state at the next edge.

Decomposition:
- Shared package holds:
  - The counter encoding constants: SNT=0, WNT=1, WT=2, ST=3.
  - The BTB entry struct/fields: valid, tag, target.
  - Default parameter values.
- One natural sub-module: return_addr_stack, containing the RAS storage, pointer and count logic.
- The PHT, BTB and GHR stay in the top.

Test Plan:
- Reset, then fetch_pc=0, no ret: pred_taken=0, pred_target=1, pred_hit=0, mispredict_count=0.
- Train branch at PC 6 with target 20, taken twice, fetch_pc=6 between updates:
  - First update: counter 1->2, GHR=0001.
  - Next lookup of PC 6 uses idx 6^1=7; that counter is still 1, so pred_hit=1 and pred_taken=0.
  - Further updates at the correct idx saturate the counter to 3; then pred_taken=1, target=20.
- Alias check: BTB holds PC 6; fetch_pc=14 (same index, different tag) gives pred_hit=0 and pred_target=15.
- RAS, RAS_DEPTH=4:
  - Push calls at PCs 1,2,3,4,5 (5 pushes); then 4 rets predict 6,5,4,3.
  - A 5th ret falls through to BTB/PHT, with pred_target = fetch_pc+1 when there is no BTB hit.
- Simultaneous fetch_is_call and fetch_is_ret at PC 9 with top=4: top becomes 10, count unchanged.
- ras_flush in the same cycle as a push: count=0 next cycle. Assert upd_mispredict for 2**CNT_W+3 cycles: counter holds at all-ones.
